// File: rtl/game_pkg.sv
// Shared types for the game-state counter: mode, match result and FSM state encodings.
package game_pkg;

    typedef enum logic [1:0] {
        UP_S = 2'b00,
        UP_L = 2'b01,
        DN_S = 2'b10,
        DN_L = 2'b11
    } ctrl_e;

    typedef enum logic [1:0] {
        NONE   = 2'b00,
        LOSER  = 2'b01,
        WINNER = 2'b10
    } who_e;

    typedef enum logic {
        PLAY = 1'b0,
        OVER = 1'b1
    } state_e;

endpackage

// File: rtl/game_tally.sv
// Score tally: plain incrementer with synchronous clear; hit flags the increment that lands on LIMIT.
module game_tally #(
    parameter int unsigned CNT_W = 4,
    parameter int unsigned LIMIT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             hit
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
    assign hit = inc && (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/game_state_param.sv
// Parametrised game counter: stepped up/down counting with load and pause, scoring
// pulses on reaching MAX or 0, and a one-cycle OVER state when a tally reaches WIN_LIMIT.
module game_state_param
    import game_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned WIN_LIMIT  = 15,
    parameter int unsigned STEP_SMALL = 1,
    parameter int unsigned STEP_LARGE = 2,
    parameter int unsigned CNT_W      = $clog2(WIN_LIMIT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       ctrl,
    input  logic             init,
    input  logic [WIDTH-1:0] init_val,
    input  logic             pause,
    output logic [WIDTH-1:0] counter,
    output logic             winner,
    output logic             loser,
    output logic [CNT_W-1:0] win_cnt,
    output logic [CNT_W-1:0] lose_cnt,
    output logic             gameover,
    output logic [1:0]       who
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    state_e           state_q;
    logic [WIDTH-1:0] counter_q;
    logic             winner_q;
    logic             loser_q;
    logic             gameover_q;
    who_e             who_q;

    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] counter_d;
    logic             count_en;
    logic             win_inc;
    logic             lose_inc;
    logic             win_hit;
    logic             lose_hit;
    logic             tally_clr;

    always_comb begin
        step      = WIDTH'(STEP_SMALL);
        counter_d = counter_q;
        case (ctrl_e'(ctrl))
            UP_S: begin step = WIDTH'(STEP_SMALL); counter_d = counter_q + step; end
            UP_L: begin step = WIDTH'(STEP_LARGE); counter_d = counter_q + step; end
            DN_S: begin step = WIDTH'(STEP_SMALL); counter_d = counter_q - step; end
            DN_L: begin step = WIDTH'(STEP_LARGE); counter_d = counter_q - step; end
            default: begin step = '0; counter_d = counter_q; end
        endcase
    end

    // Only genuine count updates score; loads, pauses and the OVER cycle never do.
    assign count_en  = (state_q == PLAY) && !init && !pause;
    assign win_inc   = count_en && (counter_d == MAX_VAL);
    assign lose_inc  = count_en && (counter_d == '0);
    assign tally_clr = (state_q == OVER);

    game_tally #(
        .CNT_W (CNT_W),
        .LIMIT (WIN_LIMIT)
    ) u_win_tally (
        .clk (clk),
        .rst (rst),
        .inc (win_inc),
        .clr (tally_clr),
        .cnt (win_cnt),
        .hit (win_hit)
    );

    game_tally #(
        .CNT_W (CNT_W),
        .LIMIT (WIN_LIMIT)
    ) u_lose_tally (
        .clk (clk),
        .rst (rst),
        .inc (lose_inc),
        .clr (tally_clr),
        .cnt (lose_cnt),
        .hit (lose_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= PLAY;
            counter_q  <= '0;
            winner_q   <= 1'b0;
            loser_q    <= 1'b0;
            gameover_q <= 1'b0;
            who_q      <= NONE;
        end else begin
            winner_q   <= 1'b0;
            loser_q    <= 1'b0;
            gameover_q <= 1'b0;
            case (state_q)
                OVER: begin
                    state_q <= PLAY;
                end
                PLAY: begin
                    if (init) begin
                        counter_q <= init_val;
                    end else if (!pause) begin
                        counter_q <= counter_d;
                        winner_q  <= win_inc;
                        loser_q   <= lose_inc;
                        if (win_hit) begin
                            gameover_q <= 1'b1;
                            who_q      <= WINNER;
                            state_q    <= OVER;
                        end else if (lose_hit) begin
                            gameover_q <= 1'b1;
                            who_q      <= LOSER;
                            state_q    <= OVER;
                        end
                    end
                end
                default: state_q <= PLAY;
            endcase
        end
    end

    assign counter  = counter_q;
    assign winner   = winner_q;
    assign loser    = loser_q;
    assign gameover = gameover_q;
    assign who      = who_q;

endmodule

// File: tb/tb_game_state_param.sv
// Directed testbench for game_state_param at default parameters (WIDTH=4, WIN_LIMIT=15).
module tb_game_state_param;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] ctrl;
    logic       init;
    logic [3:0] init_val;
    logic       pause;
    logic [3:0] counter;
    logic       winner;
    logic       loser;
    logic [3:0] win_cnt;
    logic [3:0] lose_cnt;
    logic       gameover;
    logic [1:0] who;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    game_state_param dut (
        .clk      (clk),
        .rst      (rst),
        .ctrl     (ctrl),
        .init     (init),
        .init_val (init_val),
        .pause    (pause),
        .counter  (counter),
        .winner   (winner),
        .loser    (loser),
        .win_cnt  (win_cnt),
        .lose_cnt (lose_cnt),
        .gameover (gameover),
        .who      (who)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; init = 1'b0; init_val = 4'd0; pause = 1'b0; ctrl = 2'b00;
        tick();
        rst = 1'b0;
        checks++; if (counter  !== 4'd0)  begin errors++; $display("FAIL reset_counter got %0d exp 0", counter); end
        checks++; if (winner   !== 1'b0)  begin errors++; $display("FAIL reset_winner got %0b exp 0", winner); end
        checks++; if (loser    !== 1'b0)  begin errors++; $display("FAIL reset_loser got %0b exp 0", loser); end
        checks++; if (win_cnt  !== 4'd0)  begin errors++; $display("FAIL reset_win_cnt got %0d exp 0", win_cnt); end
        checks++; if (lose_cnt !== 4'd0)  begin errors++; $display("FAIL reset_lose_cnt got %0d exp 0", lose_cnt); end
        checks++; if (gameover !== 1'b0)  begin errors++; $display("FAIL reset_gameover got %0b exp 0", gameover); end
        checks++; if (who      !== 2'b00) begin errors++; $display("FAIL reset_who got %0b exp 00", who); end
        pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (counter !== 4'd0) begin errors++; $display("FAIL idle_counter cyc %0d got %0d exp 0", i, counter); end
            checks++; if (winner !== 1'b0 || loser !== 1'b0 || gameover !== 1'b0)
                begin errors++; $display("FAIL idle_pulses cyc %0d got w%0b l%0b g%0b exp 000", i, winner, loser, gameover); end
            checks++; if (win_cnt !== 4'd0 || lose_cnt !== 4'd0 || who !== 2'b00)
                begin errors++; $display("FAIL idle_tallies cyc %0d got %0d/%0d who %0b exp 0/0 00", i, win_cnt, lose_cnt, who); end
        end
        pause = 1'b0;
    endtask

    task automatic test_load_up;
        init = 1'b1; init_val = 4'd13; ctrl = 2'b01;
        tick();
        checks++; if (counter !== 4'd13 || winner !== 1'b0) begin errors++; $display("FAIL load13 got %0d w%0b exp 13 w0", counter, winner); end
        init = 1'b0;
        tick();
        checks++; if (counter !== 4'd15) begin errors++; $display("FAIL up_large_max got %0d exp 15", counter); end
        checks++; if (winner !== 1'b1)   begin errors++; $display("FAIL up_large_winner got %0b exp 1", winner); end
        checks++; if (win_cnt !== 4'd1)  begin errors++; $display("FAIL up_large_win_cnt got %0d exp 1", win_cnt); end
        tick();
        checks++; if (counter !== 4'd1 || winner !== 1'b0) begin errors++; $display("FAIL up_wrap got %0d w%0b exp 1 w0", counter, winner); end
        checks++; if (win_cnt !== 4'd1) begin errors++; $display("FAIL up_wrap_win_cnt got %0d exp 1", win_cnt); end
    endtask

    task automatic test_down_pause;
        init = 1'b1; init_val = 4'd2; ctrl = 2'b10;
        tick();
        init = 1'b0;
        tick();
        checks++; if (counter !== 4'd1 || loser !== 1'b0) begin errors++; $display("FAIL down_1 got %0d l%0b exp 1 l0", counter, loser); end
        tick();
        checks++; if (counter !== 4'd0)  begin errors++; $display("FAIL down_0 got %0d exp 0", counter); end
        checks++; if (loser !== 1'b1)    begin errors++; $display("FAIL down_loser got %0b exp 1", loser); end
        checks++; if (lose_cnt !== 4'd1) begin errors++; $display("FAIL down_lose_cnt got %0d exp 1", lose_cnt); end
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (counter !== 4'd0 || loser !== 1'b0 || lose_cnt !== 4'd1)
                begin errors++; $display("FAIL pause_hold cyc %0d got %0d l%0b lc%0d exp 0 l0 lc1", i, counter, loser, lose_cnt); end
        end
        pause = 1'b0;
    endtask

    task automatic test_match_and_over;
        rst = 1'b1; tick(); rst = 1'b0;
        ctrl = 2'b00;
        for (int i = 1; i <= 15; i++) begin
            init = 1'b1; init_val = 4'd14; tick();
            init = 1'b0; tick();
            checks++; if (counter !== 4'd15 || winner !== 1'b1 || win_cnt !== 4'(i))
                begin errors++; $display("FAIL match_step %0d got %0d w%0b wc%0d exp 15 w1 wc%0d", i, counter, winner, win_cnt, i); end
            checks++; if (gameover !== (i == 15))
                begin errors++; $display("FAIL match_gameover %0d got %0b exp %0b", i, gameover, (i == 15)); end
        end
        checks++; if (who !== 2'b10) begin errors++; $display("FAIL match_who got %0b exp 10", who); end
        // OVER cycle: load request must be ignored
        init = 1'b1; init_val = 4'd7;
        tick();
        checks++; if (counter !== 4'd15) begin errors++; $display("FAIL over_hold got %0d exp 15", counter); end
        checks++; if (win_cnt !== 4'd0 || lose_cnt !== 4'd0) begin errors++; $display("FAIL over_clear got %0d/%0d exp 0/0", win_cnt, lose_cnt); end
        checks++; if (gameover !== 1'b0 || winner !== 1'b0) begin errors++; $display("FAIL over_pulses got g%0b w%0b exp g0 w0", gameover, winner); end
        checks++; if (who !== 2'b10) begin errors++; $display("FAIL over_who_hold got %0b exp 10", who); end
        tick();
        checks++; if (counter !== 4'd7) begin errors++; $display("FAIL post_over_load got %0d exp 7", counter); end
        init = 1'b0;
    endtask

    task automatic test_lose_match;
        rst = 1'b1; tick(); rst = 1'b0;
        ctrl = 2'b10;
        for (int i = 1; i <= 15; i++) begin
            init = 1'b1; init_val = 4'd1; tick();
            init = 1'b0; tick();
            checks++; if (counter !== 4'd0 || loser !== 1'b1 || lose_cnt !== 4'(i) || gameover !== (i == 15))
                begin errors++; $display("FAIL lose_step %0d got %0d l%0b lc%0d g%0b exp 0 l1 lc%0d g%0b", i, counter, loser, lose_cnt, gameover, i, (i == 15)); end
        end
        checks++; if (who !== 2'b01) begin errors++; $display("FAIL lose_who got %0b exp 01", who); end
        tick();
        checks++; if (counter !== 4'd0 || lose_cnt !== 4'd0 || loser !== 1'b0 || who !== 2'b01)
            begin errors++; $display("FAIL lose_over got %0d lc%0d l%0b who %0b exp 0 lc0 l0 01", counter, lose_cnt, loser, who); end
    endtask

    task automatic test_wrap_down;
        init = 1'b1; init_val = 4'd1; ctrl = 2'b11;
        tick();
        init = 1'b0;
        tick();
        checks++; if (counter !== 4'd15 || winner !== 1'b1 || win_cnt !== 4'd1)
            begin errors++; $display("FAIL dn_large_wrap got %0d w%0b wc%0d exp 15 w1 wc1", counter, winner, win_cnt); end
        tick();
        checks++; if (counter !== 4'd13 || winner !== 1'b0 || loser !== 1'b0)
            begin errors++; $display("FAIL dn_large_13 got %0d w%0b l%0b exp 13 w0 l0", counter, winner, loser); end
    endtask

    task automatic test_reset_in_over;
        rst = 1'b1; tick(); rst = 1'b0;
        ctrl = 2'b00;
        for (int i = 1; i <= 15; i++) begin
            init = 1'b1; init_val = 4'd14; tick();
            init = 1'b0; tick();
        end
        checks++; if (gameover !== 1'b1) begin errors++; $display("FAIL rst_over_setup got %0b exp 1", gameover); end
        rst = 1'b1; init = 1'b1; init_val = 4'd9;
        tick();
        rst = 1'b0; init = 1'b0;
        checks++; if (counter !== 4'd0 || winner !== 1'b0 || loser !== 1'b0 || gameover !== 1'b0)
            begin errors++; $display("FAIL rst_over_outs got %0d w%0b l%0b g%0b exp 0 w0 l0 g0", counter, winner, loser, gameover); end
        checks++; if (win_cnt !== 4'd0 || lose_cnt !== 4'd0 || who !== 2'b00)
            begin errors++; $display("FAIL rst_over_tallies got %0d/%0d who %0b exp 0/0 00", win_cnt, lose_cnt, who); end
    endtask

    initial begin
        rst = 1'b1; ctrl = 2'b00; init = 1'b0; init_val = 4'd0; pause = 1'b0;
        test_reset();
        test_load_up();
        test_down_pause();
        test_match_and_over();
        test_lose_match();
        test_wrap_down();
        test_reset_in_over();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
